bch_puf_seq: RTL and testbench
==============================

Name: bch_puf_seq

Overview:
- Sequencer for the RO-PUF BCH helper-data path. Owns the shared xilinx_encode and xilinx_decoder instances.
- ENROLL command:
  - Serializes a DATA_BITS response word into BITS-wide chunks for the encoder.
  - Captures the ECC chunks as helper data.
- RECONSTRUCT command:
  - Presents a noisy word to the decoder.
  - XOR-accumulates the err_out chunks into the corrected word and counts flipped bits.
- Sits between the PUF response register and the key/helper-data storage.

Parameters:
- T, 4, BCH correction capability; passed through for documentation only.
- DATA_BITS, 64, response word width; must be a multiple of BITS.
- BITS, 8, chunk width of the encoder/decoder streams.
- ECC_BITS, 28, helper width. Captured as ECC_CH = ceil(ECC_BITS/BITS) chunks.
- TIMEOUT, 255, watchdog limit in cycles. Used only with BCH_SEQ_WDOG_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0=ENROLL, 1=RECONSTRUCT
- cmd_data  in  DATA_BITS  response word (clean for ENROLL, noisy for RECONSTRUCT)
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_data  out  DATA_BITS  ENROLL: echo of cmd_data; RECONSTRUCT: corrected word
- rsp_helper  out  ECC_CH*BITS  ENROLL: captured ECC chunks; RECONSTRUCT: all zeros
- rsp_nerr  out  8  popcount of all err_out chunks (RECONSTRUCT only)
- rsp_timeout  out  1  watchdog abort flag
- enc_start  out  1  encoder start pulse
- enc_ce  out  1  encoder clock enable
- enc_data  out  BITS  encoder input chunk
- enc_first  in  1  encoder first output chunk
- enc_last  in  1  encoder last output chunk
- enc_ecc_bits  in  1  current encoder output chunk is ECC
- enc_data_out  in  BITS  encoder output chunk
- dec_start  out  1  decoder start pulse
- dec_data  out  DATA_BITS  decoder input word
- dec_err  in  BITS  decoder err_out chunk
- dec_first_out  in  1  decoder first error chunk

Behaviour:
- Clock and reset: all registers on posedge clk; rst_n low clears asynchronously.
- Reset values:
  - state=IDLE; cmd_ready=1; all other outputs 0.
  - enc_ce=0; helper, accumulator and counters 0.
- Reset mid-operation aborts to IDLE. No response is issued.
- Command accept: cmd_valid&&cmd_ready latches cmd_op and cmd_data. cmd_ready drops the next cycle.
- K = DATA_BITS/BITS chunks per word.
- States:
  - IDLE
    - accept with op=0 -> ENC_FEED.
    - accept with op=1 -> DEC_WAIT, with dec_start=1 for exactly one cycle on entry.
    - dec_data = latched word, held stable until leaving DEC_ACC.
  - ENC_FEED, K cycles:
    - enc_ce=1 throughout; enc_start=1 only on cycle 0.
    - enc_data = chunk i, MSB chunk first: chunk 0 = cmd_data[DATA_BITS-1 -: BITS].
    - After the last chunk -> ENC_COLLECT.
  - ENC_COLLECT:
    - enc_ce stays 1.
    - Each cycle with enc_ecc_bits=1 shifts enc_data_out into the helper register from the LSB end. The first ECC chunk ends in the MSB position.
    - ECC chunks beyond ECC_CH are ignored.
    - On enc_last (chunk captured if it is ECC) -> DONE.
  - DEC_WAIT: on dec_first_out -> DEC_ACC. The first chunk is accumulated on that same cycle.
  - DEC_ACC:
    - Chunk j (j=0..K-1, j=0 being the dec_first_out cycle) XORs into the accumulator slice [DATA_BITS-1-j*BITS -: BITS]. The accumulator is initialised with the latched word.
    - rsp_nerr += popcount(dec_err), saturating at 255.
    - After chunk K-1 -> DONE.
  - DONE:
    - rsp_valid=1; outputs held stable until rsp_ready.
    - On rsp_valid&&rsp_ready -> IDLE; rsp_valid drops the next cycle.
- Latency:
  - ENROLL: K cycles of feed + encoder latency + 1 cycle to rsp_valid.
  - RECONSTRUCT: decoder latency + K cycles + 1.
- Error and unexpected-input cases:
  - A second enc_first while in ENC_COLLECT is ignored.
  - dec_first_out outside DEC_WAIT/DEC_ACC is ignored.
  - cmd_valid while busy is not accepted.

Optional Feature:
- Macro: BCH_SEQ_WDOG_EN.
- When defined:
  - A cycle counter runs in ENC_COLLECT and DEC_WAIT and clears on each state entry.
  - Reaching TIMEOUT -> DONE with rsp_timeout=1, rsp_data=latched word, rsp_helper=0, rsp_nerr=0.
  - enc_ce is deasserted on abort.
- When undefined: no counter is built, rsp_timeout is tied to 0, and wait states wait indefinitely.

Test Plan:
- Reset values: hold rst_n=0 -> cmd_ready=1, rsp_valid=0, enc_ce=0. Release rst_n -> no spurious enc_start or dec_start.
- ENROLL of 64'hCAFECAFECAFECAFE with a behavioural encoder model:
  - enc_data sequence is CA,FE,CA,FE,CA,FE,CA,FE, with enc_start only on the CA cycle.
  - Model ECC chunks 11,22,33,44 -> rsp_helper=32'h11223344.
- RECONSTRUCT of 64'hCAFECAFECAFECAFE ^ 64'h0000050000001000:
  - Decoder model returns chunks 00,00,05,00,00,00,10,00 starting on dec_first_out.
  - Required: rsp_data=64'hCAFECAFECAFECAFE, rsp_nerr=3.
- Response backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and all response outputs stable, cmd_ready=0. Then rsp_ready=1 -> IDLE one cycle later.
- Reset mid-operation: assert rst_n low during DEC_ACC chunk 3 -> immediate IDLE, no rsp_valid. The next ENROLL completes correctly.
- BCH_SEQ_WDOG_EN with TIMEOUT=20: decoder model never raises dec_first_out -> rsp_valid with rsp_timeout=1 exactly 20 cycles after dec_start.

Source files
------------

// File: rtl/bch_puf_seq.sv
// Command sequencer for the RO-PUF BCH helper-data path: drives the shared encoder/decoder.
// Optional watchdog on the wait states is built when BCH_SEQ_WDOG_EN is defined.
module bch_puf_seq #(
  parameter int T         = 4,
  parameter int DATA_BITS = 64,
  parameter int BITS      = 8,
  parameter int ECC_BITS  = 28,
  parameter int TIMEOUT   = 255
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          cmd_valid,
  output logic                                          cmd_ready,
  input  logic                                          cmd_op,
  input  logic [DATA_BITS-1:0]                          cmd_data,
  output logic                                          rsp_valid,
  input  logic                                          rsp_ready,
  output logic [DATA_BITS-1:0]                          rsp_data,
  output logic [((ECC_BITS+BITS-1)/BITS)*BITS-1:0]      rsp_helper,
  output logic [7:0]                                    rsp_nerr,
  output logic                                          rsp_timeout,
  output logic                                          enc_start,
  output logic                                          enc_ce,
  output logic [BITS-1:0]                               enc_data,
  input  logic                                          enc_first,
  input  logic                                          enc_last,
  input  logic                                          enc_ecc_bits,
  input  logic [BITS-1:0]                               enc_data_out,
  output logic                                          dec_start,
  output logic [DATA_BITS-1:0]                          dec_data,
  input  logic [BITS-1:0]                               dec_err,
  input  logic                                          dec_first_out
);
  localparam int K      = DATA_BITS / BITS;
  localparam int ECC_CH = (ECC_BITS + BITS - 1) / BITS;
  localparam int HW     = ECC_CH * BITS;
  localparam int CW     = $clog2(K + 1);
  localparam int EW     = $clog2(ECC_CH + 1);

  if ((DATA_BITS % BITS) != 0 || T < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("bch_puf_seq: DATA_BITS must be a multiple of BITS; T and TIMEOUT must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ENC_FEED, S_ENC_COLLECT, S_DEC_WAIT, S_DEC_ACC, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [DATA_BITS-1:0] acc_q, acc_d;
  logic [HW-1:0]        helper_q, helper_d;
  logic [7:0]           nerr_q, nerr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EW-1:0]        ecc_cnt_q, ecc_cnt_d;
  logic                 first_seen_q, first_seen_d;
  logic                 dec_start_q, dec_start_d;
  logic [DATA_BITS-1:0] feed_sh, err_pos;
  logic [HW+BITS-1:0]   helper_sh;
  logic                 wdog_hit;

  function automatic logic [7:0] sat_add_pop(input logic [7:0] acc, input logic [BITS-1:0] e);
    logic [8:0] sum;
    sum = {1'b0, acc};
    for (int i = 0; i < BITS; i++) begin
      if (!sum[8]) sum = sum + {8'd0, e[i]};
    end
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  always_comb begin
    feed_sh   = word_q << (32'(cnt_q) * BITS);
    err_pos   = {dec_err, {(DATA_BITS-BITS){1'b0}}} >> (32'(cnt_q) * BITS);
    helper_sh = {helper_q, enc_data_out};
  end

`ifdef BCH_SEQ_WDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          timeout_q, timeout_d;
  logic          waiting;

  assign waiting  = (state_q == S_ENC_COLLECT) || (state_q == S_DEC_WAIT);
  assign wdog_hit = waiting && (wdog_q == WW'(TIMEOUT - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the watchdog abort overrides any normal transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        if (cmd_valid) state_d = cmd_op ? S_DEC_WAIT : S_ENC_FEED;
      S_ENC_FEED:    if (cnt_q == CW'(K - 1)) state_d = S_ENC_COLLECT;
      S_ENC_COLLECT: if (enc_last) state_d = S_DONE;
      S_DEC_WAIT:    if (dec_first_out) state_d = (K == 1) ? S_DONE : S_DEC_ACC;
      S_DEC_ACC:     if (cnt_q == CW'(K - 1)) state_d = S_DONE;
      S_DONE:        if (rsp_ready) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    if (wdog_hit) state_d = S_DONE;
  end

  always_comb begin
    word_d       = word_q;
    acc_d        = acc_q;
    helper_d     = helper_q;
    nerr_d       = nerr_q;
    cnt_d        = cnt_q;
    ecc_cnt_d    = ecc_cnt_q;
    first_seen_d = first_seen_q;
    dec_start_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          word_d       = cmd_data;
          acc_d        = cmd_data;
          helper_d     = '0;
          nerr_d       = '0;
          cnt_d        = '0;
          ecc_cnt_d    = '0;
          first_seen_d = 1'b0;
          dec_start_d  = cmd_op;
        end
      end
      S_ENC_FEED: cnt_d = cnt_q + 1'b1;
      S_ENC_COLLECT: begin
        if (enc_first) first_seen_d = 1'b1;
        // Only ECC chunks of the current codeword count, and only the first ECC_CH of them
        if (enc_ecc_bits && (first_seen_q || enc_first) && (ecc_cnt_q < EW'(ECC_CH))) begin
          helper_d  = helper_sh[HW-1:0];
          ecc_cnt_d = ecc_cnt_q + 1'b1;
        end
      end
      S_DEC_WAIT: begin
        if (dec_first_out) begin
          acc_d  = acc_q ^ err_pos;
          nerr_d = sat_add_pop(nerr_q, dec_err);
          cnt_d  = CW'(1);
        end
      end
      S_DEC_ACC: begin
        acc_d  = acc_q ^ err_pos;
        nerr_d = sat_add_pop(nerr_q, dec_err);
        cnt_d  = cnt_q + 1'b1;
      end
      default: ;
    endcase
    if (wdog_hit) begin
      acc_d    = word_q;
      helper_d = '0;
      nerr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q       <= '0;
      acc_q        <= '0;
      helper_q     <= '0;
      nerr_q       <= '0;
      cnt_q        <= '0;
      ecc_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      dec_start_q  <= 1'b0;
    end else begin
      word_q       <= word_d;
      acc_q        <= acc_d;
      helper_q     <= helper_d;
      nerr_q       <= nerr_d;
      cnt_q        <= cnt_d;
      ecc_cnt_q    <= ecc_cnt_d;
      first_seen_q <= first_seen_d;
      dec_start_q  <= dec_start_d;
    end
  end

`ifdef BCH_SEQ_WDOG_EN
  // Counter restarts on every state entry and only advances while waiting
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (state_d != state_q)  wdog_d = '0;
    else if (waiting)        wdog_d = wdog_q + 1'b1;
    if (state_q == S_IDLE && cmd_valid) timeout_d = 1'b0;
    if (wdog_hit)            timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Outputs
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    rsp_valid  = (state_q == S_DONE);
    enc_ce     = (state_q == S_ENC_FEED) || (state_q == S_ENC_COLLECT);
    enc_start  = (state_q == S_ENC_FEED) && (cnt_q == '0);
    enc_data   = (state_q == S_ENC_FEED) ? feed_sh[DATA_BITS-1 -: BITS] : '0;
    dec_start  = dec_start_q;
    dec_data   = word_q;
    rsp_data   = acc_q;
    rsp_helper = helper_q;
    rsp_nerr   = nerr_q;
  end

endmodule

// File: tb/tb_bch_puf_seq.sv
// Directed bench for bch_puf_seq with behavioural encoder/decoder stubs driven from the vector table.
module tb_bch_puf_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [31:0] rsp_helper;
  logic [7:0]  rsp_nerr;
  logic        rsp_timeout;
  logic        enc_start, enc_ce;
  logic [7:0]  enc_data;
  logic        enc_first = 1'b0, enc_last = 1'b0, enc_ecc_bits = 1'b0;
  logic [7:0]  enc_data_out = '0;
  logic        dec_start;
  logic [63:0] dec_data;
  logic [7:0]  dec_err = '0;
  logic        dec_first_out = 1'b0;

  int total = 0;
  int bad   = 0;

  bch_puf_seq #(.T(4), .DATA_BITS(64), .BITS(8), .ECC_BITS(28), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_helper(rsp_helper), .rsp_nerr(rsp_nerr), .rsp_timeout(rsp_timeout),
    .enc_start(enc_start), .enc_ce(enc_ce), .enc_data(enc_data),
    .enc_first(enc_first), .enc_last(enc_last), .enc_ecc_bits(enc_ecc_bits),
    .enc_data_out(enc_data_out),
    .dec_start(dec_start), .dec_data(dec_data), .dec_err(dec_err),
    .dec_first_out(dec_first_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running want done");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic        op;       // 0 enroll, 1 reconstruct
    logic [63:0] din;
    logic [63:0] model;    // enroll: ECC word in [31:0]; reconstruct: error pattern
    logic        extra;    // enroll: emit a 5th ECC chunk and a stray enc_first
    logic [63:0] exp_data;
    logic [31:0] exp_helper;
    logic [7:0]  exp_nerr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic op, input logic [63:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_enroll_body(input vec_t v);
    logic [63:0] t;
    for (int i = 0; i < 8; i++) begin
      t = v.din >> (56 - 8 * i);
      chk($sformatf("enc_data[%0d]", i), {56'd0, enc_data}, {56'd0, t[7:0]});
      chk($sformatf("enc_start[%0d]", i), {63'd0, enc_start}, {63'd0, (i == 0)});
      chk($sformatf("enc_ce_feed[%0d]", i), {63'd0, enc_ce}, 64'd1);
      step();
    end
    step();
    step();
    // encoder output stream: 8 systematic chunks then ECC chunks
    for (int c = 0; c < (v.extra ? 13 : 12); c++) begin
      t = v.model >> (56 - 8 * (c - 8) - 32);
      enc_first    = (c == 0) || (v.extra && c == 10);
      enc_last     = (c == (v.extra ? 12 : 11));
      enc_ecc_bits = (c >= 8);
      if (c < 8) begin
        t = v.din >> (56 - 8 * c);
        enc_data_out = t[7:0];
      end else if (c < 12) begin
        t = v.model >> (24 - 8 * (c - 8));
        enc_data_out = t[7:0];
      end else begin
        enc_data_out = 8'h77;
      end
      chk("enc_ce_collect", {63'd0, enc_ce}, 64'd1);
      step();
    end
    enc_first = 1'b0; enc_last = 1'b0; enc_ecc_bits = 1'b0; enc_data_out = '0;
  endtask

  task automatic run_dec_body(input vec_t v, input int stop_at);
    logic [63:0] t;
    chk("dec_start_pulse", {63'd0, dec_start}, 64'd1);
    chk("dec_data", dec_data, v.din);
    step();
    chk("dec_start_low", {63'd0, dec_start}, 64'd0);
    step();
    for (int j = 0; j < 8; j++) begin
      t = v.model >> (56 - 8 * j);
      dec_first_out = (j == 0);
      dec_err       = t[7:0];
      if (j == stop_at) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        dec_first_out = 1'b0; dec_err = '0;
        return;
      end
      step();
    end
    dec_first_out = 1'b0; dec_err = '0;
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    accept(v.op, v.din);
    if (v.op) run_dec_body(v, -1);
    else      run_enroll_body(v);
    chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_helper", {32'd0, rsp_helper}, {32'd0, v.exp_helper});
    chk("rsp_nerr", {56'd0, rsp_nerr}, {56'd0, v.exp_nerr});
    chk("rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_op = ~v.op; cmd_data = 64'h5555_AAAA_5555_AAAA;
      step();
      chk("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      chk("hold_rsp_data", rsp_data, v.exp_data);
      chk("hold_rsp_helper", {32'd0, rsp_helper}, {32'd0, v.exp_helper});
      chk("hold_rsp_nerr", {56'd0, rsp_nerr}, {56'd0, v.exp_nerr});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("post_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    step();
    chk("idle_enc_ce", {63'd0, enc_ce}, 64'd0);
    chk("idle_dec_start", {63'd0, dec_start}, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 64'hCAFECAFECAFECAFE, 64'h11223344, 1'b0,
                64'hCAFECAFECAFECAFE, 32'h11223344, 8'd0};
    vecs[1] = '{1'b1, 64'hCAFECFFECAFEDAFE, 64'h0000050000001000, 1'b0,
                64'hCAFECAFECAFECAFE, 32'h0, 8'd3};
    vecs[2] = '{1'b0, 64'h0123456789ABCDEF, 64'hDEADBEEF, 1'b1,
                64'h0123456789ABCDEF, 32'hDEADBEEF, 8'd0};
    vecs[3] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0,
                64'h0000000000000000, 32'h0, 8'd64};
    vecs[4] = '{1'b1, 64'h0000000000000000, 64'h8000000000000001, 1'b0,
                64'h8000000000000001, 32'h0, 8'd2};
    vecs[5] = '{1'b0, 64'h0000000000000000, 64'hA5A5A5A5, 1'b0,
                64'h0000000000000000, 32'hA5A5A5A5, 8'd0};

    // reset values
    #3;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_enc_ce", {63'd0, enc_ce}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rel_enc_start", {63'd0, enc_start}, 64'd0);
      chk("rel_dec_start", {63'd0, dec_start}, 64'd0);
    end

    // stray decoder output while idle must be ignored
    dec_first_out = 1'b1; dec_err = 8'hFF;
    step();
    dec_first_out = 1'b0; dec_err = '0;
    chk("stray_dec_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    for (int n = 0; n < 6; n++) run_vec(vecs[n], (n == 1) ? 10 : 0);

    // reset during DEC_ACC chunk 3
    accept(1'b1, vecs[1].din);
    run_dec_body(vecs[1], 3);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("after_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    end
    run_vec(vecs[0], 0);

`ifdef BCH_SEQ_WDOG_EN
    begin
      int n;
      accept(1'b1, 64'h1234_5678_9ABC_DEF0);
      chk("wd_dec_start", {63'd0, dec_start}, 64'd1);
      n = 0;
      while (!rsp_valid && n < 40) begin
        step();
        n++;
      end
      chk("wd_latency", 64'(n), 64'd20);
      chk("wd_timeout", {63'd0, rsp_timeout}, 64'd1);
      chk("wd_rsp_data", rsp_data, 64'h1234_5678_9ABC_DEF0);
      chk("wd_rsp_helper", {32'd0, rsp_helper}, 64'd0);
      chk("wd_rsp_nerr", {56'd0, rsp_nerr}, 64'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("wd_post_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
